// File: rtl/hack_pkg.sv
// hack_pkg: shared widths and reset vector for the Hack CPU front end
package hack_pkg;
  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_INSTR_WIDTH = 16;
  localparam logic [DEF_ADDR_WIDTH-1:0] RESET_VECTOR = '0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small register FIFO with synchronous clear and a gated head output
module sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign dout = valid ? mem[rd_ptr] : '0;
  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  // storage; callers never push into a full FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: walks instruction ROM and prefetches words for the decode stage
module instruction_fetch
  import hack_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            pc_in,
  input  logic                   pc_load,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic                   rom_en,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready
);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_WIDTH-1:0] fetch_pc, tag;
  logic inflight, flush, push;
  logic [CW-1:0] count;
  logic [INSTR_WIDTH+ADDR_WIDTH-1:0] head;
  logic unused_pc_in;
  assign unused_pc_in = ^pc_in;
  assign flush = !reset || pc_load;
  assign push = inflight && !flush;
  assign rom_en = !flush && (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign rom_addr = fetch_pc;
  assign {instr, instr_pc} = head;
  // fetch pointer, in-flight flag and tag of the word coming back next cycle
  always_ff @(posedge clk) begin
    if (flush) begin
      inflight <= 1'b0;
      fetch_pc <= !reset ? ADDR_WIDTH'(RESET_VECTOR) : pc_in[ADDR_WIDTH-1:0];
    end else begin
      inflight <= rom_en;
      if (rom_en) begin
        fetch_pc <= fetch_pc + 1'b1;
        tag <= fetch_pc;
      end
    end
  end
  sync_fifo #(.WIDTH(INSTR_WIDTH+ADDR_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clear (flush),
    .push  (push),
    .din   ({rom_data, tag}),
    .pop   (instr_ready),
    .dout  (head),
    .valid (instr_valid),
    .count (count)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random and directed scoreboard bench for instruction_fetch
module tb_instruction_fetch;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 0, pc_load = 0, instr_ready = 0;
  logic [15:0] pc_in = 0;
  logic [14:0] rom_addr, instr_pc;
  logic rom_en, instr_valid;
  logic [15:0] rom_data = 0, instr;
  instruction_fetch dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_load(pc_load),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );
  // ROM content is a function of its address, so a stale word shows up as a wrong pair
  always @(posedge clk) if (rom_en) rom_data <= {1'b0, rom_addr} ^ 16'hA5A5;
  int checks = 0, errors = 0;
  logic [14:0] q[$];
  logic [14:0] acc[$];
  logic pv = 0;
  logic [14:0] pa = 0, fpc = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(bit r, bit l, logic [15:0] p, bit rdy);
    bit en;
    @(negedge clk);
    reset = r; pc_load = l; pc_in = p; instr_ready = rdy;
    #1;
    en = r && !l && (q.size() + int'(pv)) < 4;
    check("rom_en", rom_en, en);
    if (en) check("rom_addr", rom_addr, fpc);
    check("instr_valid", instr_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("instr_pc", instr_pc, q[0]);
      check("instr", instr, {1'b0, q[0]} ^ 16'hA5A5);
    end
    if (instr_valid && rdy) acc.push_back(instr_pc);
    @(posedge clk);
    if (!r) begin
      q.delete(); pv = 0; fpc = 0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (l) begin
        q.delete(); pv = 0; fpc = p[14:0];
      end else begin
        if (pv) q.push_back(pa);
        pv = en;
        if (en) begin pa = fpc; fpc = fpc + 1'b1; end
      end
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    step(0, 0, 0, 1);
    step(0, 1, 16'h1234, 1);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    acc.delete();
    repeat (12) step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) check("seq_pc", acc[i], i);
    repeat (10) step(1, 0, 0, 0);
    check("full_rom_en", rom_en, 0);
    acc.delete();
    repeat (8) step(1, 0, 0, 1);
    check("release_first", acc[0], 10);
    check("release_cnt", acc.size(), 8);
    step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    acc.delete();
    step(1, 1, 16'h0100, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("redir_gap", acc.size(), 0);
    repeat (3) step(1, 0, 0, 1);
    check("redir_first", acc[0], 15'h0100);
    step(1, 1, 16'h0200, 1);
    acc.delete();
    step(1, 1, 16'h7FFE, 1);
    repeat (6) step(1, 0, 0, 1);
    check("wrap0", acc[0], 15'h7FFE);
    check("wrap1", acc[1], 15'h7FFF);
    check("wrap2", acc[2], 15'h0000);
    check("wrap3", acc[3], 15'h0001);
    repeat (8) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    acc.delete();
    repeat (5) step(1, 0, 0, 1);
    check("restart_pc", acc[0], 0);
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 499) != 0, $urandom_range(0, 15) == 0,
           16'($urandom), $urandom_range(0, 3) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
